// File: rtl/uart_pkg.sv
// Shared UART rate table and constant helpers for the bit-rate generators.
package uart_pkg;
  typedef logic [1:0] baud_sel_t;

  localparam int NUM_RATES = 4;
  localparam int BAUD_TABLE [NUM_RATES] = '{9600, 19200, 57600, 115200};

  // Round-to-nearest divisor keeps the rate error symmetric.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int calc_mid(input int div);
    return div / 2;
  endfunction

  function automatic int calc_osd(input int div, input int os);
    return div / os;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bps_gen_multi_os_tick_gen.sv
// Oversample tick generator: OVERSAMPLE ticks of period osd per bit, then holds until cleared.
module os_tick_gen import uart_pkg::*; #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic [CNT_W-1:0]               osd,
  output logic                           os_tick,
  output logic [clog2(OVERSAMPLE)-1:0]   os_idx
);
  localparam int IW = clog2(OVERSAMPLE);

  logic [CNT_W-1:0] r_os_cnt;
  logic [IW:0]      r_ticks;
  logic [IW-1:0]    r_idx;
  logic             r_tick;
  logic             w_done, w_hit;

  assign w_done = (r_ticks == (IW+1)'(OVERSAMPLE));
  assign w_hit  = en && !w_done && (r_os_cnt == osd - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os_cnt <= '0;
      r_ticks  <= '0;
      r_idx    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= w_hit;
      // A tick coinciding with the bit wrap still reports its own index.
      if (w_hit)    r_idx <= r_ticks[IW-1:0];
      else if (clr) r_idx <= '0;
      if (clr) begin
        r_os_cnt <= '0;
        r_ticks  <= '0;
      end else if (en && !w_done) begin
        r_os_cnt <= w_hit ? '0 : r_os_cnt + CNT_W'(1);
        if (w_hit) r_ticks <= r_ticks + (IW+1)'(1);
      end
    end
  end

  assign os_tick = r_tick;
  assign os_idx  = r_idx;
endmodule

// File: rtl/bps_gen_multi.sv
// Multi-rate UART bit-rate generator: mid-bit, end-of-bit and oversample strobes.
module bps_gen_multi import uart_pkg::*; #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD0      = BAUD_TABLE[0],
  parameter int BAUD1      = BAUD_TABLE[1],
  parameter int BAUD2      = BAUD_TABLE[2],
  parameter int BAUD3      = BAUD_TABLE[3],
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 16
) (
  input  logic                         sysclk,
  input  logic                         rst,
  input  logic                         count_sig,
  input  logic                         restart,
  input  baud_sel_t                    baud_sel,
  output logic                         clk_bps,
  output logic                         bit_end,
  output logic                         os_tick,
  output logic [clog2(OVERSAMPLE)-1:0] os_idx,
  output baud_sel_t                    sel_active
);
  localparam int DIV_I [NUM_RATES] = '{calc_div(CLK_HZ, BAUD0), calc_div(CLK_HZ, BAUD1),
                                       calc_div(CLK_HZ, BAUD2), calc_div(CLK_HZ, BAUD3)};
  localparam int MID_I [NUM_RATES] = '{calc_mid(DIV_I[0]), calc_mid(DIV_I[1]),
                                       calc_mid(DIV_I[2]), calc_mid(DIV_I[3])};
  localparam int OSD_I [NUM_RATES] = '{calc_osd(DIV_I[0], OVERSAMPLE), calc_osd(DIV_I[1], OVERSAMPLE),
                                       calc_osd(DIV_I[2], OVERSAMPLE), calc_osd(DIV_I[3], OVERSAMPLE)};

  if ((1 << clog2(OVERSAMPLE)) != OVERSAMPLE || OVERSAMPLE < 2) begin : g_bad_os
    $fatal(1, "OVERSAMPLE must be a power of 2 and at least 2");
  end
  for (genvar i = 0; i < NUM_RATES; i++) begin : g_chk
    if (longint'(DIV_I[i]) > (longint'(1) << CNT_W) - 1) begin : g_big
      $fatal(1, "divisor %0d does not fit in CNT_W bits", i);
    end
    if (DIV_I[i] < 2 * OVERSAMPLE) begin : g_small
      $fatal(1, "divisor %0d smaller than 2*OVERSAMPLE", i);
    end
  end

  logic [CNT_W-1:0] r_cnt, r_div, r_mid, r_osd;
  logic             r_clk_bps, r_bit_end;
  baud_sel_t        r_sel;
  logic             w_wrap, w_os_clr, w_os_en;

  assign w_wrap = (r_cnt == r_div - CNT_W'(1));

  // Divisor registers load alongside the rate index, so they are valid on the first counting edge.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clk_bps <= 1'b0;
      r_bit_end <= 1'b0;
      r_sel     <= '0;
      r_div     <= CNT_W'(DIV_I[0]);
      r_mid     <= CNT_W'(MID_I[0]);
      r_osd     <= CNT_W'(OSD_I[0]);
    end else if (restart) begin
      r_cnt     <= '0;
      r_clk_bps <= 1'b0;
      r_bit_end <= 1'b0;
    end else if (!count_sig) begin
      r_cnt     <= '0;
      r_clk_bps <= 1'b0;
      r_bit_end <= 1'b0;
      r_sel     <= baud_sel;
      r_div     <= CNT_W'(DIV_I[baud_sel]);
      r_mid     <= CNT_W'(MID_I[baud_sel]);
      r_osd     <= CNT_W'(OSD_I[baud_sel]);
    end else begin
      r_cnt     <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_clk_bps <= (r_cnt == r_mid);
      r_bit_end <= w_wrap;
    end
  end

  assign w_os_clr = restart | ~count_sig | w_wrap;
  assign w_os_en  = count_sig & ~restart;

  os_tick_gen #(.OVERSAMPLE(OVERSAMPLE), .CNT_W(CNT_W)) u_os (
    .clk     (sysclk),
    .rst     (rst),
    .clr     (w_os_clr),
    .en      (w_os_en),
    .osd     (r_osd),
    .os_tick (os_tick),
    .os_idx  (os_idx)
  );

  assign clk_bps    = r_clk_bps;
  assign bit_end    = r_bit_end;
  assign sel_active = r_sel;
endmodule

// File: tb/tb_bps_gen_multi.sv
// Randomized-interval scoreboard bench for bps_gen_multi against an edge-number timing model.
module tb_bps_gen_multi;
  localparam int CLK_HZ = 50_000_000;
  localparam int OS     = 16;
  localparam int BAUDS [4] = '{9600, 19200, 57600, 115200};

  typedef struct {int cyc; int idx;} ev_t;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic       count_sig = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] baud_sel = 2'd0;
  logic       clk_bps, bit_end, os_tick;
  logic [3:0] os_idx;
  logic [1:0] sel_active;

  bps_gen_multi dut (
    .sysclk(sysclk), .rst(rst), .count_sig(count_sig), .restart(restart),
    .baud_sel(baud_sel), .clk_bps(clk_bps), .bit_end(bit_end), .os_tick(os_tick),
    .os_idx(os_idx), .sel_active(sel_active)
  );

  always #5 sysclk = ~sysclk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_sel = 0;
  ev_t  q_bps[$];
  ev_t  q_be[$];
  ev_t  q_os[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  // The active rate is whatever baud_sel was on the most recent idle edge.
  always @(posedge sysclk or posedge rst)
    if (rst) m_sel <= 0;
    else if (!restart && !count_sig) m_sel <= int'(baud_sel);

  function automatic int div_of(input int s);
    return (CLK_HZ + BAUDS[s] / 2) / BAUDS[s];
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected strobes of a run whose edge 0 is absolute edge s and which lasts n edges.
  task automatic plan(input int s, input int n, input int div);
    int osd, r;
    ev_t ev;
    osd = div / OS;
    for (int e = 0; e < n; e++) begin
      r = e % div;
      ev.cyc = s + e;
      ev.idx = 0;
      if (r == div / 2) q_bps.push_back(ev);
      if (r == div - 1) q_be.push_back(ev);
      if ((r + 1) % osd == 0 && (r + 1) / osd >= 1 && (r + 1) / osd <= OS) begin
        ev.idx = (r + 1) / osd - 1;
        q_os.push_back(ev);
      end
    end
  endtask

  // Count for n edges; baud_sel is scrambled at edge chg_at to show it is ignored mid-run.
  task automatic seg(input int n, input int chg_at, input logic [1:0] chg_sel);
    plan(cyc + 1, n, div_of(m_sel));
    count_sig = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      if (i == chg_at) baud_sel = chg_sel;
    end
  endtask

  task automatic end_idle();
    count_sig = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic end_restart();
    restart = 1'b1;
    @(negedge sysclk);
    restart = 1'b0;
  endtask

  task automatic judge(input string nm, input logic obs, input logic hit,
                       input bit chk_idx, input int exp_idx);
    if (obs || hit) begin
      n_cmp++;
      if (obs != hit) begin
        n_bad++;
        $display("FAIL %s: strobe=%0d, expected %0d (cycle %0d)", nm, obs, hit, cyc);
      end else if (chk_idx && int'(os_idx) != exp_idx) begin
        n_bad++;
        $display("FAIL os_idx: got %0d, expected %0d (cycle %0d)", os_idx, exp_idx, cyc);
      end
    end
  endtask

  // Monitor: compares every cycle in which the DUT or the model has a strobe.
  initial begin
    logic hit;
    forever begin
      @(negedge sysclk);
      if (!rst) begin
        while (q_bps.size() > 0 && q_bps[0].cyc < cyc) void'(q_bps.pop_front());
        while (q_be.size()  > 0 && q_be[0].cyc  < cyc) void'(q_be.pop_front());
        while (q_os.size()  > 0 && q_os[0].cyc  < cyc) void'(q_os.pop_front());
        hit = q_bps.size() > 0 && q_bps[0].cyc == cyc;
        judge("clk_bps", clk_bps, hit, 1'b0, 0);
        if (hit) void'(q_bps.pop_front());
        hit = q_be.size() > 0 && q_be[0].cyc == cyc;
        judge("bit_end", bit_end, hit, 1'b0, 0);
        if (hit) void'(q_be.pop_front());
        hit = q_os.size() > 0 && q_os[0].cyc == cyc;
        judge("os_tick", os_tick, hit, 1'b1, hit ? q_os[0].idx : 0);
        if (hit) void'(q_os.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_bps"}, int'(clk_bps), 0);
    check({tag, "_bit_end"}, int'(bit_end), 0);
    check({tag, "_os_tick"}, int'(os_tick), 0);
    check({tag, "_os_idx"},  int'(os_idx), 0);
    check({tag, "_sel"},     int'(sel_active), 0);
  endtask

  initial begin
    int gap, n;
    #1 rst = 1'b1;
    #3 check_all_zero("reset");
    baud_sel = 2'd3;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    // 115200: ten bits, mid/end/oversample timing.
    seg(10 * 434, -1, 2'd0);
    check("sel_after_run", int'(sel_active), 3);
    end_idle();

    // 9600 with baud_sel scrambled mid-run, then a one-cycle idle applies 115200.
    baud_sel = 2'd0;
    gap = $urandom_range(1, 4);
    repeat (gap) @(negedge sysclk);
    seg(2 * 5208 + 5, 1000, 2'd3);
    check("sel_held_mid_run", int'(sel_active), 0);
    end_idle();
    seg(3 * 434, -1, 2'd0);
    check("sel_switched", int'(sel_active), 3);
    end_idle();

    // count_sig dropped at edge 300 for 5 cycles.
    seg(300, -1, 2'd0);
    count_sig = 1'b0;
    repeat (5) @(negedge sysclk);
    seg(434 + 300, -1, 2'd0);
    end_idle();

    // Restart at edge 200, then randomized-length re-phase runs.
    seg(200, -1, 2'd0);
    end_restart();
    seg(500, -1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(20, 900);
      end_restart();
      seg(n, -1, 2'd0);
    end
    end_idle();

    // Asynchronous reset while cnt = 100.
    seg(100, -1, 2'd0);
    #2 rst = 1'b1;
    count_sig = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    seg(3 * 434, -1, 2'd0);
    end_idle();

    repeat (20) @(negedge sysclk);
    check("leftover_expected", q_bps.size() + q_be.size() + q_os.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
